// File: rtl/lfsr_rng_arbiter_pkg.sv
// Shared types and constants for the LFSR random-byte arbiter.
// Optional build macro: LFSR_RNG_ROUND_ROBIN_EN (round-robin instead of fixed priority).
package lfsr_rng_arbiter_pkg;
  localparam int              LFSR_WIDTH    = 8;
  localparam logic [7:0]      LFSR_ZERO_SUB = 8'h01;
  localparam logic [7:0]      LFSR_TAPS     = 8'b0111_1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    STEP  = 2'd2,
    GRANT = 2'd3
  } state_e;

  // Galois-style shift: rotate left, XOR the outgoing MSB into bits 3..6.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
    return {s[LFSR_WIDTH-2:0], s[LFSR_WIDTH-1]} ^ (s[LFSR_WIDTH-1] ? LFSR_TAPS : 8'h00);
  endfunction
endpackage

// File: rtl/lfsr_rng_arbiter_if.sv
// Requester-side bus of the LFSR arbiter: seed control, req/gnt and random byte.
interface lfsr_rng_arbiter_if #(parameter int NREQ = 4);
  import lfsr_rng_arbiter_pkg::*;
  logic                  seed_load;
  logic [LFSR_WIDTH-1:0] seed_value;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       gnt;
  logic [LFSR_WIDTH-1:0] rnd_data;
  logic                  rnd_valid;
  logic                  busy;

  modport master (output seed_load, seed_value, req,
                  input  gnt, rnd_data, rnd_valid, busy);
  modport slave  (input  seed_load, seed_value, req,
                  output gnt, rnd_data, rnd_valid, busy);
endinterface

// File: rtl/lfsr8_core.sv
// 8-bit LFSR register with synchronous load and shift enable.
module lfsr8_core
  import lfsr_rng_arbiter_pkg::*;
#(
  parameter logic [7:0] SEED_DEFAULT = 8'hFF
) (
  input  logic       CLK1,
  input  logic       KEY0,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] state
);
  always_ff @(posedge CLK1 or negedge KEY0) begin
    if (!KEY0)     state <= SEED_DEFAULT;
    else if (load) state <= load_val;
    else if (en)   state <= lfsr_next(state);
  end
endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Arbitrates one LFSR among NREQ requesters: seed, STEPS shifts, then one-cycle grant.
// Optional build macro: LFSR_RNG_ROUND_ROBIN_EN (round-robin; default fixed priority).
module lfsr_rng_arbiter
  import lfsr_rng_arbiter_pkg::*;
#(
  parameter int         NREQ         = 4,
  parameter int         STEPS        = 2,
  parameter logic [7:0] SEED_DEFAULT = 8'hFF
) (
  input  logic CLK1,
  input  logic KEY0,
  lfsr_rng_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          r_state, w_next;
  logic [IW-1:0]   r_win, w_win;
  logic            w_any;
  logic [3:0]      r_cnt;
  logic [7:0]      r_seed;
  logic [NREQ-1:0] r_gnt;
  logic            r_valid;
  logic [7:0]      r_rnd;
  logic [7:0]      w_lfsr;
  logic            w_en, w_load;

`ifdef LFSR_RNG_ROUND_ROBIN_EN
  localparam logic [IW:0]   NREQ_W = (IW+1)'(NREQ);
  localparam logic [IW-1:0] LAST   = IW'(NREQ-1);
  logic [IW-1:0] r_ptr;
  logic [IW:0]   w_sum;

  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_sum = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(i);
      if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
      if (!w_any && bus.req[w_sum[IW-1:0]]) begin
        w_win = w_sum[IW-1:0];
        w_any = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (bus.req[i]) begin
        w_win = IW'(i);
        w_any = 1'b1;
      end
    end
  end
`endif

  lfsr8_core #(.SEED_DEFAULT(SEED_DEFAULT)) u_core (
    .CLK1     (CLK1),
    .KEY0     (KEY0),
    .en       (w_en),
    .load     (w_load),
    .load_val ((r_seed == 8'h00) ? LFSR_ZERO_SUB : r_seed),
    .state    (w_lfsr)
  );

  always_comb begin
    w_next = r_state;
    w_en   = 1'b0;
    w_load = 1'b0;
    case (r_state)
      IDLE:    if (bus.seed_load) w_next = SEED;
               else if (w_any)    w_next = STEP;
      SEED:    begin w_load = 1'b1; w_next = IDLE; end
      STEP:    begin w_en = 1'b1; if (r_cnt == 4'd1) w_next = GRANT; end
      GRANT:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK1 or negedge KEY0) begin
    if (!KEY0) begin
      r_state <= IDLE;
      r_win   <= '0;
      r_cnt   <= '0;
      r_seed  <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_rnd   <= 8'h00;
`ifdef LFSR_RNG_ROUND_ROBIN_EN
      r_ptr   <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.seed_load) r_seed <= bus.seed_value;
        else if (w_any) begin
          r_win <= w_win;
          r_cnt <= 4'(STEPS);
        end
      end
      // Outputs are registered on the last shift, so the byte is the post-shift LFSR value.
      if (r_state == STEP) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << r_win;
          r_valid <= 1'b1;
          r_rnd   <= lfsr_next(w_lfsr);
        end
      end
`ifdef LFSR_RNG_ROUND_ROBIN_EN
      if (r_state == GRANT) r_ptr <= (r_win == LAST) ? '0 : r_win + 1'b1;
`endif
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rnd_valid = r_valid;
  assign bus.rnd_data  = r_rnd;
  assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Directed bench for lfsr_rng_arbiter (NREQ=4, STEPS=2), hand-computed LFSR values.
module tb_lfsr_rng_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  lfsr_rng_arbiter_if #(.NREQ(4)) bus ();

  lfsr_rng_arbiter #(.NREQ(4), .STEPS(2), .SEED_DEFAULT(8'hFF)) dut (
    .CLK1 (clk),
    .KEY0 (rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_gnt(input int budget, output int lat, output logic [3:0] g,
                          output logic [7:0] d, output logic v);
    lat = -1; g = '0; d = '0; v = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.gnt != 4'b0) begin
        lat = i; g = bus.gnt; d = bus.rnd_data; v = bus.rnd_valid;
        break;
      end
    end
  endtask

  // Waits for a grant, checks latency/grant/valid and optionally the byte; drops req when asked.
  task automatic expect_grant(input string tag, input int lat_e, input logic [3:0] g_e,
                              input bit chk_d, input logic [7:0] d_e, input bit drop);
    int lat; logic [3:0] g; logic [7:0] d; logic v;
    wait_gnt(12, lat, g, d, v);
    chk({tag, "_lat"}, lat, lat_e);
    chk({tag, "_gnt"}, {28'd0, g}, {28'd0, g_e});
    chk({tag, "_vld"}, {31'd0, v}, 32'd1);
    if (chk_d) chk({tag, "_data"}, {24'd0, d}, {24'd0, d_e});
    if (drop) begin bus.req = 4'b0; bus.seed_load = 1'b0; end
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_gnt", {28'd0, bus.gnt}, 32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rr_exp [5];
`ifdef LFSR_RNG_ROUND_ROBIN_EN
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    bus.seed_load = 1'b0; bus.seed_value = 8'h00; bus.req = 4'b0;

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_gnt",  {28'd0, bus.gnt}, 32'd0);
    chk("reset_vld",  {31'd0, bus.rnd_valid}, 32'd0);
    chk("reset_data", {24'd0, bus.rnd_data}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);

    // Single requester: FF -> 87 -> 77, busy through the grant cycle
    bus.req = 4'b0001;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      chk("r0_busy_step", {31'd0, bus.busy}, 32'd1);
      chk("r0_nogrant",   {28'd0, bus.gnt}, 32'd0);
    end
    @(negedge clk);
    chk("r0_gnt",  {28'd0, bus.gnt}, 32'd1);
    chk("r0_data", {24'd0, bus.rnd_data}, 32'h77);
    chk("r0_vld",  {31'd0, bus.rnd_valid}, 32'd1);
    chk("r0_busy_gnt", {31'd0, bus.busy}, 32'd1);
    bus.req = 4'b0;
    @(negedge clk);
    chk("r0_gnt_pulse", {28'd0, bus.gnt}, 32'd0);
    chk("r0_vld_pulse", {31'd0, bus.rnd_valid}, 32'd0);
    chk("r0_data_hold", {24'd0, bus.rnd_data}, 32'h77);
    chk("r0_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Zero seed is replaced by 01: 01 -> 02 -> 04
    bus.seed_load = 1'b1; bus.seed_value = 8'h00;
    @(negedge clk);
    chk("seed_busy", {31'd0, bus.busy}, 32'd1);
    bus.seed_load = 1'b0; bus.req = 4'b0100;
    expect_grant("seed0", 4, 4'b0100, 1'b1, 8'h04, 1'b1);

    // All requesters held: round-robin or fixed priority
    rst_pulse();
    @(negedge clk);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++)
      expect_grant($sformatf("all%0d", k), (k == 0) ? 3 : 4, rr_exp[k], (k == 0), 8'h77, (k == 4));

    // seed_load wins over req in the same cycle: 5A -> B4 -> 11
    @(negedge clk);
    bus.seed_load = 1'b1; bus.seed_value = 8'h5A; bus.req = 4'b0010;
    @(negedge clk);
    bus.seed_load = 1'b0;
    expect_grant("seedpri", 4, 4'b0010, 1'b1, 8'h11, 1'b1);

    // Reset during STEP aborts the grant; held req[3] then gets 77
    @(negedge clk);
    bus.req = 4'b1000;
    @(negedge clk);
    chk("abort_busy_pre", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_gnt",  {28'd0, bus.gnt}, 32'd0);
    #1 rst_n = 1'b1;
    expect_grant("abort", 3, 4'b1000, 1'b1, 8'h77, 1'b1);

    // seed_load during STEP is ignored
    rst_pulse();
    @(negedge clk);
    bus.req = 4'b0001;
    @(negedge clk);
    bus.seed_load = 1'b1; bus.seed_value = 8'h33;
    expect_grant("midseed", 2, 4'b0001, 1'b1, 8'h77, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("midseed_idle", {31'd0, bus.busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
